// File: rtl/rectangle128_pkg.sv
// Shared constants and types for the RECTANGLE-128 sequencer.
package rectangle128_pkg;

    localparam int NR    = 25;          // full rounds
    localparam int NRK   = NR + 1;      // round keys held in the schedule memory
    localparam int RK_AW = 5;           // round-key memory address width

    // Address constants sized to the memory port, so comparisons stay width-exact.
    localparam logic [RK_AW-1:0] RK_LAST   = RK_AW'(NRK - 1);
    localparam logic [RK_AW-1:0] RND_LAST  = RK_AW'(NR - 1);
    localparam logic [RK_AW-1:0] FIN_INDEX = RK_AW'(NR);

    typedef logic [63:0] rkey_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        READY = 3'd2,
        ENC   = 3'd3,
        FIN   = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/rectangle128_rkmem.sv
// Round-key register file: NRK x 64, one synchronous write port and one
// asynchronous read port. Storage is not reset; validity is tracked by the
// controller's key_loaded flag.
module rectangle128_rkmem
    import rectangle128_pkg::*;
(
    input  logic             Clk,
    input  logic             we,
    input  logic [RK_AW-1:0] waddr,
    input  logic [63:0]      wdata,
    input  logic [RK_AW-1:0] raddr,
    output logic [63:0]      rdata
);

    rkey_t mem [NRK];

    // Capture one round key per enabled write; the caller keeps waddr < NRK.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rectangle128_ctrl.sv
// RECTANGLE-128 sequencer: loads a key, restarts the key-schedule generator,
// captures the 26 round keys, then steps the round datapath once per cycle
// for each accepted plaintext block and holds the result until taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid (and its data) until that edge; ready may
// depend combinationally on valid, a valid never depends on ready. When a key
// and a block are both offered in READY, the key wins and in_ready stays low.
module rectangle128_ctrl
    import rectangle128_pkg::*;
(
    input  logic             Clk,
    input  logic             RstN,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [63:0]      key0,
    input  logic [63:0]      key1,
    output logic             skg_restart,
    output logic             skg_en,
    output logic [63:0]      skg_key0,
    output logic [63:0]      skg_key1,
    input  logic             skg_we,
    input  logic [RK_AW-1:0] skg_waddr,
    input  logic [63:0]      skg_kin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dp_load,
    output logic             dp_round,
    output logic             dp_final,
    output logic [63:0]      dp_rk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             key_loaded,
    output state_e           dbg_state,
    output logic [RK_AW-1:0] dbg_wcount
);

    state_e           state_q;
    logic [RK_AW-1:0] rnd_q;
    logic [RK_AW-1:0] wcnt_q;
    logic             key_acc;
    logic             blk_acc;
    logic             wr_ok;
    logic [RK_AW-1:0] rd_addr;
    rkey_t            rd_data;

    // Handshake decode is combinational from state and the offered valids.
    assign key_ready   = (state_q == IDLE) || (state_q == READY);
    assign in_ready    = (state_q == READY) && !key_valid;
    assign key_acc     = key_valid && key_ready;
    assign blk_acc     = in_valid && in_ready;
    assign skg_restart = key_acc;
    assign dp_load     = blk_acc;

    // Only in-range schedule writes seen while expanding reach the memory.
    assign wr_ok = (state_q == KEXP) && skg_we && (skg_waddr <= RK_LAST);

    // FIN reads the last key; otherwise the round counter selects the entry.
    assign rd_addr = dp_final ? FIN_INDEX : rnd_q;
    assign dp_rk   = (dp_round || dp_final) ? rd_data : '0;

    assign dbg_state  = state_q;
    assign dbg_wcount = wcnt_q;

    rectangle128_rkmem u_rkmem (
        .Clk   (Clk),
        .we    (wr_ok),
        .waddr (skg_waddr),
        .wdata (skg_kin),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Sequencer FSM with registered datapath/schedule controls.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q    <= IDLE;
            rnd_q      <= '0;
            wcnt_q     <= '0;
            skg_en     <= 1'b0;
            skg_key0   <= '0;
            skg_key1   <= '0;
            dp_round   <= 1'b0;
            dp_final   <= 1'b0;
            out_valid  <= 1'b0;
            key_loaded <= 1'b0;
        end else begin
            case (state_q)
                IDLE, READY: begin
                    if (key_acc) begin
                        skg_key0   <= key0;
                        skg_key1   <= key1;
                        key_loaded <= 1'b0;
                        skg_en     <= 1'b1;
                        wcnt_q     <= '0;
                        state_q    <= KEXP;
                    end else if (blk_acc) begin
                        rnd_q    <= '0;
                        dp_round <= 1'b1;
                        state_q  <= ENC;
                    end
                end
                KEXP: begin
                    if (wr_ok) begin
                        wcnt_q <= wcnt_q + 1'b1;
                        if (skg_waddr == RK_LAST) begin
                            key_loaded <= 1'b1;
                            skg_en     <= 1'b0;
                            state_q    <= READY;
                        end
                    end
                end
                ENC: begin
                    if (rnd_q == RND_LAST) begin
                        rnd_q    <= '0;
                        dp_round <= 1'b0;
                        dp_final <= 1'b1;
                        state_q  <= FIN;
                    end else begin
                        rnd_q <= rnd_q + 1'b1;
                    end
                end
                FIN: begin
                    dp_final  <= 1'b0;
                    out_valid <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= READY;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rectangle128_ctrl.sv
// Bench for rectangle128_ctrl: a stand-in key-schedule generator, a
// cycle-level reference model built from the handshake/schedule rules,
// a vector table for the first handshakes, directed corner sequences and
// a randomized phase.
module tb_rectangle128_ctrl;
    import rectangle128_pkg::*;

    typedef struct {
        logic kv;
        logic iv;
        logic ordy;
        logic e_kr;
        logic e_ir;
        logic e_rst;
        logic e_load;
    } vec_t;

    logic        Clk;
    logic        RstN;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key0;
    logic [63:0] key1;
    logic        skg_restart;
    logic        skg_en;
    logic [63:0] skg_key0;
    logic [63:0] skg_key1;
    logic        skg_we;
    logic [4:0]  skg_waddr;
    logic [63:0] skg_kin;
    logic        in_valid;
    logic        in_ready;
    logic        dp_load;
    logic        dp_round;
    logic        dp_final;
    logic [63:0] dp_rk;
    logic        out_valid;
    logic        out_ready;
    logic        key_loaded;
    state_e      dbg_state;
    logic [4:0]  dbg_wcount;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: what the sequencer is doing, in plain terms.
    bit          m_kexp;     // schedule capture in progress
    bit          m_loaded;   // complete schedule held
    bit          m_done;     // ciphertext waiting for the sink
    int          m_step;     // -1 idle, 0..NR-1 rounds, NR final step
    int          m_wc;       // counted schedule writes
    logic [63:0] m_k0, m_k1;

    // Stand-in key-schedule generator.
    bit          s_active, s_loaded, bubble_en, junk_en;
    int          s_idx;
    logic [63:0] s_k0, s_k1;

    // Values sampled in the most recent cycle.
    logic smp_kr, smp_ir, smp_rst, smp_load, smp_round, smp_final, smp_ov, smp_kl;

    rectangle128_ctrl dut (
        .Clk         (Clk),
        .RstN        (RstN),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key0        (key0),
        .key1        (key1),
        .skg_restart (skg_restart),
        .skg_en      (skg_en),
        .skg_key0    (skg_key0),
        .skg_key1    (skg_key1),
        .skg_we      (skg_we),
        .skg_waddr   (skg_waddr),
        .skg_kin     (skg_kin),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dp_load     (dp_load),
        .dp_round    (dp_round),
        .dp_final    (dp_final),
        .dp_rk       (dp_rk),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .key_loaded  (key_loaded),
        .dbg_state   (dbg_state),
        .dbg_wcount  (dbg_wcount)
    );

    // Clock and watchdog.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Deterministic schedule produced by the stand-in generator for a key.
    function automatic logic [63:0] rk_gen(input logic [63:0] k0, input logic [63:0] k1, input int idx);
        logic [63:0] v;
        v = (k0 + 64'(idx + 1) * 64'h9E37_79B9_7F4A_7C15) ^ {k1[31:0], k1[63:32]};
        return v ^ (v >> 29) ^ 64'(idx);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic reset_models();
        m_kexp = 0; m_loaded = 0; m_done = 0; m_step = -1; m_wc = 0;
        m_k0 = '0; m_k1 = '0;
        s_active = 0; s_loaded = 0; s_idx = 0; s_k0 = '0; s_k1 = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_key_ready"},   64'(key_ready),   64'd1);
        chk({tag, "_in_ready"},    64'(in_ready),    64'd0);
        chk({tag, "_out_valid"},   64'(out_valid),   64'd0);
        chk({tag, "_skg_en"},      64'(skg_en),      64'd0);
        chk({tag, "_skg_restart"}, 64'(skg_restart), 64'd0);
        chk({tag, "_dp_load"},     64'(dp_load),     64'd0);
        chk({tag, "_dp_round"},    64'(dp_round),    64'd0);
        chk({tag, "_dp_final"},    64'(dp_final),    64'd0);
        chk({tag, "_dp_rk"},       dp_rk,            64'd0);
        chk({tag, "_key_loaded"},  64'(key_loaded),  64'd0);
        chk({tag, "_skg_key0"},    skg_key0,         64'd0);
        chk({tag, "_skg_key1"},    skg_key1,         64'd0);
        chk({tag, "_wcount"},      64'(dbg_wcount),  64'd0);
        chk({tag, "_state"},       64'(dbg_state),   64'(IDLE));
    endtask

    // Called at a falling edge: pull reset mid-cycle, check the asynchronous
    // return to reset values, release on the next falling edge.
    task automatic do_async_reset(input string tag);
        key_valid = 0; in_valid = 0; skg_we = 0;
        #2;
        RstN = 0;
        #1;
        check_reset_values(tag);
        reset_models();
        @(posedge Clk);
        @(negedge Clk);
        RstN = 1;
    endtask

    // One clock cycle: generator drive, sampling, model comparison, update.
    task automatic step();
        bit          e_kr, e_ir, e_round, e_final, s_write;
        logic [63:0] e_rk;
        s_write = 0;
        if (s_active && s_loaded && s_idx < NRK) begin
            if (bubble_en && $urandom_range(0, 7) == 0) begin
                skg_we    = 1'b1;
                skg_waddr = 5'($urandom_range(NRK, 31));
                skg_kin   = {$urandom, $urandom};
            end else begin
                skg_we    = 1'b1;
                skg_waddr = 5'(s_idx);
                skg_kin   = rk_gen(s_k0, s_k1, s_idx);
                s_write   = 1;
            end
        end else if (!s_active && junk_en) begin
            skg_we    = 1'($urandom_range(0, 1));
            skg_waddr = 5'($urandom_range(0, 31));
            skg_kin   = {$urandom, $urandom};
        end else begin
            skg_we = 1'b0; skg_waddr = '0; skg_kin = '0;
        end
        #1;
        smp_kr = key_ready; smp_ir = in_ready; smp_rst = skg_restart; smp_load = dp_load;
        smp_round = dp_round; smp_final = dp_final; smp_ov = out_valid; smp_kl = key_loaded;

        e_kr    = !m_kexp && (m_step < 0) && !m_done;
        e_ir    = e_kr && m_loaded && !key_valid;
        e_round = (m_step >= 0) && (m_step < NR);
        e_final = (m_step == NR);
        e_rk    = (e_round || e_final) ? rk_gen(m_k0, m_k1, m_step) : 64'd0;

        chk("key_ready",   64'(key_ready),   64'(e_kr));
        chk("in_ready",    64'(in_ready),    64'(e_ir));
        chk("skg_restart", 64'(skg_restart), 64'(key_valid && e_kr));
        chk("dp_load",     64'(dp_load),     64'(in_valid && e_ir));
        chk("dp_round",    64'(dp_round),    64'(e_round));
        chk("dp_final",    64'(dp_final),    64'(e_final));
        chk("dp_rk",       dp_rk,            e_rk);
        chk("out_valid",   64'(out_valid),   64'(m_done));
        chk("skg_en",      64'(skg_en),      64'(m_kexp));
        chk("key_loaded",  64'(key_loaded),  64'(m_loaded));
        chk("skg_key0",    skg_key0,         m_k0);
        chk("skg_key1",    skg_key1,         m_k1);
        chk("wcount",      64'(dbg_wcount),  64'(m_wc));

        if (key_valid && e_kr) begin
            m_kexp = 1; m_loaded = 0; m_wc = 0; m_k0 = key0; m_k1 = key1;
        end else if (in_valid && e_ir) begin
            m_step = 0;
        end else if (m_kexp) begin
            if (skg_we && skg_waddr < 5'(NRK)) m_wc++;
            if (skg_we && skg_waddr == 5'(NRK - 1)) begin
                m_kexp = 0; m_loaded = 1;
            end
        end else if (m_step >= 0) begin
            if (m_step == NR) begin
                m_step = -1; m_done = 1;
            end else begin
                m_step++;
            end
        end else if (m_done && out_ready) begin
            m_done = 0;
        end

        if (smp_rst) begin
            s_active = 1; s_loaded = 0; s_idx = 0;
        end else if (s_active && !s_loaded) begin
            if (skg_en) begin
                s_loaded = 1; s_k0 = skg_key0; s_k1 = skg_key1;
            end
        end else if (s_write) begin
            s_idx++;
            if (s_idx == NRK) s_active = 0;
        end

        @(posedge Clk);
        @(negedge Clk);
        cyc++;
    endtask

    // Let any running job finish and return to an accepting state.
    task automatic drain(input string tag);
        int n;
        key_valid = 0; in_valid = 0; out_ready = 1;
        n = 0;
        do begin
            step();
            n++;
        end while (!smp_kr && n < 100);
        chk({tag, "_drain_idle"}, 64'(smp_kr), 64'd1);
    endtask

    initial begin
        vec_t tbl[6];
        int   n, zeros, cnt_round, cnt_final, n_first, loads, t1, t2;
        int   order[$];

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        RstN = 0; key_valid = 0; in_valid = 0; out_ready = 0;
        key0 = '0; key1 = '0; skg_we = 0; skg_waddr = '0; skg_kin = '0;
        bubble_en = 0; junk_en = 1;
        reset_models();
        @(negedge Clk);
        #1;
        check_reset_values("por");
        @(negedge Clk);
        RstN = 1;

        // Handshake vectors from reset: ignored block, key accept with all-zero key, KEXP.
        for (int i = 0; i < 6; i++) begin
            key_valid = tbl[i].kv; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            step();
            chk($sformatf("tbl%0d_key_ready", i),   64'(smp_kr),   64'(tbl[i].e_kr));
            chk($sformatf("tbl%0d_in_ready", i),    64'(smp_ir),   64'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_skg_restart", i), 64'(smp_rst),  64'(tbl[i].e_rst));
            chk($sformatf("tbl%0d_dp_load", i),     64'(smp_load), 64'(tbl[i].e_load));
        end
        key_valid = 0; in_valid = 0;
        zeros = 3; n = 0;
        while (n < 60) begin
            step();
            n++;
            if (smp_kr) break;
            zeros++;
        end
        chk("key_busy_cycles", 64'(zeros), 64'd27);
        chk("key_loaded_after_kexp", 64'(smp_kl), 64'd1);

        // Block accept, round/final counts and latency to out_valid.
        out_ready = 0; in_valid = 1;
        step();
        chk("blk_dp_load", 64'(smp_load), 64'd1);
        in_valid = 0; n = 0; cnt_round = 0; cnt_final = 0;
        do begin
            step();
            n++;
            if (smp_round) cnt_round++;
            if (smp_final) cnt_final++;
        end while (!smp_ov && n < 60);
        chk("blk_latency", 64'(n), 64'd27);
        chk("blk_rounds", 64'(cnt_round), 64'(NR));
        chk("blk_finals", 64'(cnt_final), 64'd1);

        // Sink stalls ten cycles; key and block offers are ignored.
        key_valid = 1; key0 = {$urandom, $urandom}; key1 = {$urandom, $urandom}; in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_out_valid", 64'(smp_ov), 64'd1);
            chk("stall_in_ready", 64'(smp_ir), 64'd0);
            chk("stall_restart", 64'(smp_rst), 64'd0);
        end
        key_valid = 0; in_valid = 0; out_ready = 1;
        step();
        out_ready = 0;
        step();
        chk("release_in_ready", 64'(smp_ir), 64'd1);

        // Key and block offered during KEXP are held; key then block once READY.
        key0 = {$urandom, $urandom}; key1 = {$urandom, $urandom}; key_valid = 1;
        step();
        chk("rekey_accept", 64'(smp_rst), 64'd1);
        key0 = {$urandom, $urandom}; key1 = {$urandom, $urandom};
        key_valid = 1; in_valid = 1; n = 0; n_first = 0;
        while (order.size() < 2 && n < 200) begin
            step();
            n++;
            if (smp_rst) begin
                order.push_back(1); key_valid = 0;
                if (n_first == 0) n_first = n;
            end
            if (smp_load) begin
                order.push_back(2); in_valid = 0;
            end
        end
        chk("order_count", 64'(order.size()), 64'd2);
        chk("order_first_key", 64'((order.size() > 0) ? order[0] : 0), 64'd1);
        chk("order_second_blk", 64'((order.size() > 1) ? order[1] : 0), 64'd2);
        chk("held_key_accept_cycle", 64'(n_first), 64'd28);
        drain("order");

        // Asynchronous reset during round 12; a new key is needed afterwards.
        in_valid = 1;
        step();
        chk("pre_rst_dp_load", 64'(smp_load), 64'd1);
        in_valid = 0;
        repeat (12) step();
        do_async_reset("mid_enc");
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_in_ready", 64'(smp_ir), 64'd0);
        end
        in_valid = 0;
        key0 = {$urandom, $urandom}; key1 = {$urandom, $urandom}; key_valid = 1;
        step();
        key_valid = 0;
        drain("post_rst_key");
        chk("post_rst_key_loaded", 64'(smp_kl), 64'd1);

        // Rekey with all-ones key, then back-to-back blocks with the sink ready.
        key0 = '1; key1 = '1; key_valid = 1;
        step();
        key_valid = 0;
        step();
        chk("ones_key_loaded_drop", 64'(smp_kl), 64'd0);
        drain("ones_kexp");
        out_ready = 1; in_valid = 1; loads = 0; n = 0; t1 = 0; t2 = 0;
        while (loads < 2 && n < 100) begin
            step();
            n++;
            if (smp_load) begin
                if (loads == 0) t1 = n; else t2 = n;
                loads++;
            end
        end
        in_valid = 0;
        chk("blk_interval", 64'(t2 - t1), 64'd28);
        drain("interval");

        // Randomized traffic: generator bubbles, stray writes, rare resets.
        bubble_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!key_valid && $urandom_range(0, 39) == 0) begin
                key_valid = 1; key0 = {$urandom, $urandom}; key1 = {$urandom, $urandom};
            end
            in_valid  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 599) == 0) begin
                do_async_reset("rand_rst");
            end else begin
                step();
                if (smp_rst) key_valid = 0;
            end
        end
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rectangle128_ctrl.md
# rectangle128_ctrl

Sequencer for the RECTANGLE-128 core. It takes a 128-bit key and restarts the key-schedule generator, then captures the 26 generated 64-bit round keys into a local round-key memory. It then runs the 25-round encryption datapath for each accepted plaintext block, feeding one round key per cycle, and holds the result under a valid/ready handshake. It sits between the host-side stream interfaces and the skeygen/round datapath instances.

## Interface
- NR, 25, number of full rounds
- NRK, 26, number of round keys (NR+1)
- Clk  in  1  clock, all state on rising edge
- RstN  in  1  asynchronous, active-low reset
- key_valid  in  1  new key offered
- key_ready  out  1  key accepted this cycle when both high
- key0, key1  in  64 each  key words, latched on accept
- skg_restart  out  1  synchronous clear of skeygen round counter
- skg_en  out  1  skeygen Enable
- skg_key0, skg_key1  out  64 each  registered key words driven to skeygen
- skg_we, skg_waddr, skg_kin  in  1/5/64  skeygen memory-write port
- in_valid, in_ready  in/out  1  plaintext handshake
- dp_load  out  1  datapath loads plaintext (in datapath, not here)
- dp_round  out  1  datapath performs AddRoundKey+SubColumn+ShiftRow
- dp_final  out  1  datapath performs final AddRoundKey only
- dp_rk  out  64  round key for the current datapath step
- out_valid, out_ready  out/in  1  ciphertext handshake (data held in datapath)
- key_loaded  out  1  round-key memory holds a complete schedule

## Operation
- Reset values: state IDLE, key_ready=1, in_ready=0, out_valid=0, skg_en=0, skg_restart=0, dp_*=0, dp_rk=0, key_loaded=0, skg_key*=0, round counter=0, write counter=0.
- States: IDLE, KEXP, READY, ENC, FIN, DONE.
- key_ready=1 only in IDLE and READY. A key accept in these states:
  - skg_restart=1 combinationally in the accept cycle.
  - key0/key1 latched into skg_key*.
  - key_loaded cleared.
  - Go to KEXP.
- KEXP:
  - skg_en=1.
  - Each cycle with skg_we=1 writes skg_kin to memory[skg_waddr]; the write counter increments.
  - The write with skg_waddr=NRK-1 sets key_loaded=1 and moves to READY.
  - skg_we outside KEXP is ignored.
  - Write addresses ≥NRK are ignored and not counted.
- in_ready=1 only in READY. A block accept:
  - dp_load=1 combinationally in the accept cycle.
  - Round counter r=0.
  - Go to ENC.
- ENC:
  - dp_round=1, dp_rk=memory[r].
  - r increments each cycle.
  - After r=NR-1, go to FIN.
- FIN: dp_final=1, dp_rk=memory[NR]; go to DONE.
- DONE:
  - out_valid=1 until out_valid&out_ready, then go to READY.
  - out_valid may not drop without the handshake.
- key_valid during KEXP/ENC/FIN/DONE is ignored and must be held by the source.
- in_valid in IDLE/KEXP is not accepted; in_ready stays 0.
- dp_rk=0 whenever dp_round and dp_final are both 0.
- RstN low at any time, including mid-KEXP or mid-ENC, returns to reset values immediately. Memory contents need not clear, but key_loaded=0 invalidates them.

## Timing
- Key accept at edge E0:
  - skeygen loads the key at E1.
  - Writes addr 0..25 occur at E2..E27.
  - key_ready and in_ready are high from the cycle after E27, i.e. 27 cycles after accept.
- Block accept at E0:
  - Rounds at E1..E25 with keys 0..24.
  - Final step at E26 with key 25.
  - out_valid high in the cycle after E26.
  - Minimum block-to-block interval is 28 cycles with out_ready held high.
- skg_restart, dp_load, key_ready and in_ready are combinational from state and handshake. dp_rk is combinational from the memory read. All other outputs are registered.

## Structure
- Package rectangle128_pkg holds:
  - NR, NRK.
  - State enum type.
  - Round-key type (logic [63:0]).
- Sub-module rectangle128_rkmem: NRK×64 register file with one write port and one asynchronous read port; no reset on storage.

## Test plan
- Reset then key accept with key0=64'h0, key1=64'h0 → skg_restart pulse in accept cycle; key_ready=0 for exactly 27 cycles; memory[0..25] matches golden skeygen model.
- Block accept with pt=64'h0 after key load → dp_load in accept cycle; dp_round for 25 cycles with dp_rk=memory[0..24]; dp_final one cycle with memory[25]; out_valid in cycle 27.
- out_ready held low 10 cycles in DONE → out_valid stays 1, in_ready stays 0, key_valid ignored; release → READY next cycle.
- key_valid and in_valid asserted during KEXP → neither accepted; both accepted in order once READY.
- RstN asserted at round 12 of ENC → all outputs return to reset values asynchronously; key_loaded=0; a new key is required before in_ready rises.
- Rekey with key0=key1=64'hFFFF_FFFF_FFFF_FFFF from READY → key_loaded drops, new schedule captured; an encryption afterwards uses only the new keys.
